// File: rtl/pi_digit_packer.sv
// Packs a stream of BCD digits into DPD groups and 18-bit pi memory words.
// Optional input digit checking is enabled by defining PI_DIGIT_PACKER_CHECK_EN.
module pi_digit_packer #(
    parameter int N     = 24,
    parameter int MEM_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       in_digit,
    output logic             in_ready,
    input  logic             flush,
    output logic             mem_we,
    output logic [N-1:0]     mem_addr,
    output logic [MEM_W-1:0] mem_d,
    output logic [N-1:0]     digit_count,
    output logic             done,
    output logic             err
);

    localparam int         ACC_W      = 28;
    localparam logic [4:0] GROUP_BITS = 5'd10;
    localparam logic [4:0] WORD_BITS  = 5'(MEM_W);

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    logic [1:0]       r_phase;
    logic [3:0]       r_hund;
    logic [3:0]       r_tens;
    logic [9:0]       r_group;
    logic             r_groupValid;
    logic [ACC_W-1:0] r_acc;
    logic [4:0]       r_fill;
    logic             r_memWe;
    logic [N-1:0]     r_memAddr;
    logic [N-1:0]     r_wordIdx;
    logic [MEM_W-1:0] r_memD;
    logic [N-1:0]     r_digitCount;
    logic             r_done;

    logic             w_accept;
    logic             w_pad;
    logic             w_finalEmit;
    logic             w_doneSet;
    logic [3:0]       w_digit;
    logic [3:0]       w_tensIn;
    logic [3:0]       w_unitsIn;
    logic [9:0]       w_groupIn;
    logic [ACC_W-1:0] w_accSum;
    logic [4:0]       w_fillSum;

    // IEEE 754-2008 densely packed decimal: three BCD digits into 10 bits.
    function automatic logic [9:0] dpdEncode(input logic [3:0] dh,
                                             input logic [3:0] dt,
                                             input logic [3:0] du);
        logic a, b, c, d, e, f, g, h, i, j, k, m;
        logic [9:0] code;
        {a, b, c, d} = dh;
        {e, f, g, h} = dt;
        {i, j, k, m} = du;
        case ({a, e, i})
            3'b000:  code = {b, c, d, f, g, h, 1'b0, j, k, m};
            3'b001:  code = {b, c, d, f, g, h, 1'b1, 1'b0, 1'b0, m};
            3'b010:  code = {b, c, d, j, k, h, 1'b1, 1'b0, 1'b1, m};
            3'b011:  code = {b, c, d, 1'b1, 1'b0, h, 1'b1, 1'b1, 1'b1, m};
            3'b100:  code = {j, k, d, f, g, h, 1'b1, 1'b1, 1'b0, m};
            3'b101:  code = {f, g, d, 1'b0, 1'b1, h, 1'b1, 1'b1, 1'b1, m};
            3'b110:  code = {j, k, d, 1'b0, 1'b0, h, 1'b1, 1'b1, 1'b1, m};
            default: code = {1'b0, 1'b0, d, 1'b1, 1'b1, h, 1'b1, 1'b1, 1'b1, m};
        endcase
        return code;
    endfunction

`ifdef PI_DIGIT_PACKER_CHECK_EN
    logic w_digitBad;
    logic r_err;

    assign w_digitBad = (in_digit > 4'd9);
    assign w_digit    = w_digitBad ? 4'd0 : in_digit;
    assign err        = r_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_accept && w_digitBad) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_digit = in_digit;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Flush completes a partial triplet first, then waits for the group
    // register to empty so the accumulator holds every pending bit.
    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_pad       = 1'b0;
        w_finalEmit = 1'b0;
        w_doneSet   = 1'b0;
        in_ready    = 1'b0;
        case (r_state)
            S_RUN: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (flush) begin
                    w_stateNext = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_phase != 2'd0) begin
                    w_pad = 1'b1;
                end else if (!r_groupValid) begin
                    w_finalEmit = (r_fill != 5'd0);
                    w_doneSet   = 1'b1;
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                w_stateNext = S_DONE;
            end
            default: begin
                w_stateNext = S_RUN;
            end
        endcase
    end

    // The group is formed from the stored digits and either the incoming
    // units digit or zero padding when flushing a partial triplet.
    always_comb begin
        w_tensIn  = (r_phase == 2'd2) ? r_tens : 4'd0;
        w_unitsIn = w_accept ? w_digit : 4'd0;
        w_groupIn = dpdEncode(r_hund, w_tensIn, w_unitsIn);
    end

    always_comb begin
        w_accSum  = r_acc;
        w_fillSum = r_fill;
        if (r_groupValid) begin
            w_accSum  = r_acc | (ACC_W'(r_group) << r_fill);
            w_fillSum = r_fill + GROUP_BITS;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_phase      <= 2'd0;
            r_hund       <= 4'd0;
            r_tens       <= 4'd0;
            r_group      <= 10'd0;
            r_groupValid <= 1'b0;
            r_digitCount <= '0;
        end else begin
            r_groupValid <= 1'b0;
            if (w_accept) begin
                r_digitCount <= r_digitCount + N'(1);
                case (r_phase)
                    2'd0: begin
                        r_hund  <= w_digit;
                        r_phase <= 2'd1;
                    end
                    2'd1: begin
                        r_tens  <= w_digit;
                        r_phase <= 2'd2;
                    end
                    default: begin
                        r_group      <= w_groupIn;
                        r_groupValid <= 1'b1;
                        r_phase      <= 2'd0;
                    end
                endcase
            end else if (w_pad) begin
                r_group      <= w_groupIn;
                r_groupValid <= 1'b1;
                r_phase      <= 2'd0;
            end
        end
    end

    // Fill never exceeds 17 after an update, so one emit per cycle suffices.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc     <= '0;
            r_fill    <= 5'd0;
            r_memWe   <= 1'b0;
            r_memAddr <= '0;
            r_wordIdx <= '0;
            r_memD    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_memWe <= 1'b0;
            r_done  <= w_doneSet;
            if (w_finalEmit) begin
                r_memWe   <= 1'b1;
                r_memD    <= r_acc[MEM_W-1:0];
                r_memAddr <= r_wordIdx;
                r_wordIdx <= r_wordIdx + N'(1);
                r_acc     <= '0;
                r_fill    <= 5'd0;
            end else if (w_fillSum >= WORD_BITS) begin
                r_memWe   <= 1'b1;
                r_memD    <= w_accSum[MEM_W-1:0];
                r_memAddr <= r_wordIdx;
                r_wordIdx <= r_wordIdx + N'(1);
                r_acc     <= w_accSum >> MEM_W;
                r_fill    <= w_fillSum - WORD_BITS;
            end else begin
                r_acc  <= w_accSum;
                r_fill <= w_fillSum;
            end
        end
    end

    assign mem_we      = r_memWe;
    assign mem_addr    = r_memAddr;
    assign mem_d       = r_memD;
    assign digit_count = r_digitCount;
    assign done        = r_done;

endmodule

// File: tb/tb_pi_digit_packer.sv
// Self-checking bench for pi_digit_packer: table vectors, hand-written
// corner sequences and randomized runs against a bit-queue reference model.
module tb_pi_digit_packer;

    localparam int N = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [3:0]   in_digit;
    logic         in_ready;
    logic         flush;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [17:0]  mem_d;
    logic [N-1:0] digit_count;
    logic         done;
    logic         err;

    pi_digit_packer #(.N(N), .MEM_W(18)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_digit    (in_digit),
        .in_ready    (in_ready),
        .flush       (flush),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_d       (mem_d),
        .digit_count (digit_count),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  nDigits;
        logic [23:0] digits;
        logic [1:0]  nWords;
        logic [53:0] words;
    } vec_t;

    int testsRun  = 0;
    int failCount = 0;

    int           stimDigits[$];
    logic [17:0]  expWords[$];
    logic [17:0]  capData[$];
    logic [N-1:0] capAddr[$];
    int           doneCount = 0;

    logic [9:0] dpdTable[1000];
    bit         dpdSet[1000];

    // Every write and done pulse while out of reset is logged for later checks.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (mem_we === 1'b1) begin
                capAddr.push_back(mem_addr);
                capData.push_back(mem_d);
            end
            if (done === 1'b1) begin
                doneCount++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // DPD decode; the encoder table is built by inverting it over all codes.
    function automatic int dpdValue(input logic [9:0] c);
        logic p, q, r, s, t, u, v, w, x, y;
        logic [3:0] d2, d1, d0;
        {p, q, r, s, t, u, v, w, x, y} = c;
        d2 = {1'b0, p, q, r};
        d1 = {1'b0, s, t, u};
        d0 = {1'b0, w, x, y};
        if (v) begin
            case ({w, x})
                2'b00: d0 = {3'b100, y};
                2'b01: begin d1 = {3'b100, u}; d0 = {1'b0, s, t, y}; end
                2'b10: begin d2 = {3'b100, r}; d0 = {1'b0, p, q, y}; end
                default: begin
                    case ({s, t})
                        2'b00: begin d2 = {3'b100, r}; d1 = {3'b100, u}; d0 = {1'b0, p, q, y}; end
                        2'b01: begin d2 = {3'b100, r}; d1 = {1'b0, p, q, u}; d0 = {3'b100, y}; end
                        2'b10: begin d1 = {3'b100, u}; d0 = {3'b100, y}; end
                        default: begin d2 = {3'b100, r}; d1 = {3'b100, u}; d0 = {3'b100, y}; end
                    endcase
                end
            endcase
        end
        return int'(d2) * 100 + int'(d1) * 10 + int'(d0);
    endfunction

    task automatic buildDpdTable();
        int val;
        for (int code = 0; code < 1024; code++) begin
            val = dpdValue(10'(code));
            if (!dpdSet[val]) begin
                dpdSet[val]   = 1'b1;
                dpdTable[val] = 10'(code);
            end
        end
    endtask

    // Reference: a flat bit stream, 10 bits per padded triplet, cut into 18-bit words.
    task automatic modelPack();
        bit bq[$];
        int n, h, tt, uu;
        logic [9:0]  code;
        logic [17:0] wd;
        expWords.delete();
        n = stimDigits.size();
        for (int g = 0; g * 3 < n; g++) begin
            h    = stimDigits[3 * g];
            tt   = (3 * g + 1 < n) ? stimDigits[3 * g + 1] : 0;
            uu   = (3 * g + 2 < n) ? stimDigits[3 * g + 2] : 0;
            code = dpdTable[h * 100 + tt * 10 + uu];
            for (int b = 0; b < 10; b++) bq.push_back(code[b]);
            while (bq.size() >= 18) begin
                for (int b = 0; b < 18; b++) wd[b] = bq.pop_front();
                expWords.push_back(wd);
            end
        end
        if (bq.size() > 0) begin
            wd = '0;
            for (int b = 0; bq.size() > 0; b++) wd[b] = bq.pop_front();
            expWords.push_back(wd);
        end
    endtask

    task automatic doReset();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_digit = 4'd0;
        flush    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        capAddr.delete();
        capData.delete();
        doneCount = 0;
        rst = 1'b1;
    endtask

    task automatic sendDigit(input int d);
        in_valid = 1'b1;
        in_digit = 4'(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int gapMax, input bit flushWithLast);
        int n, gaps;
        n = stimDigits.size();
        for (int i = 0; i < n; i++) begin
            gaps = (gapMax > 0) ? $urandom_range(gapMax, 0) : 0;
            repeat (gaps) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_digit = 4'(stimDigits[i]);
            flush    = flushWithLast && (i == n - 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            flush    = 1'b0;
        end
        if (!flushWithLast || n == 0) begin
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
        end
    endtask

    task automatic collectAndCheck(input string name);
        int waited = 0;
        int nCmp;
        while (doneCount == 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        checkOutput($sformatf("%s done seen", name), 32'(doneCount > 0), 32'd1);
        repeat (4) @(negedge clk);
        checkOutput($sformatf("%s write count", name), 32'(capData.size()), 32'(expWords.size()));
        nCmp = (capData.size() < expWords.size()) ? capData.size() : expWords.size();
        for (int i = 0; i < nCmp; i++) begin
            checkOutput($sformatf("%s addr[%0d]", name, i), 32'(capAddr[i]), 32'(i));
            checkOutput($sformatf("%s data[%0d]", name, i), 32'(capData[i]), 32'(expWords[i]));
        end
        checkOutput($sformatf("%s digit_count", name), 32'(digit_count), 32'(stimDigits.size()));
        checkOutput($sformatf("%s done pulses", name), 32'(doneCount), 32'd1);
    endtask

    initial begin
        vec_t vecs[5];
        int   nd;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_digit = 4'd0;
        flush    = 1'b0;
        buildDpdTable();

        vecs[0] = '{nDigits: 4'd6, digits: 24'h314159, nWords: 2'd2, words: {18'h36594, 18'h00000, 18'h0}};
        vecs[1] = '{nDigits: 4'd3, digits: 24'h141000, nWords: 2'd1, words: {18'h000C1, 18'h0, 18'h0}};
        vecs[2] = '{nDigits: 4'd2, digits: 24'h770000, nWords: 2'd1, words: {18'h003F0, 18'h0, 18'h0}};
        vecs[3] = '{nDigits: 4'd3, digits: 24'h000000, nWords: 2'd1, words: {18'h00000, 18'h0, 18'h0}};
        vecs[4] = '{nDigits: 4'd0, digits: 24'h000000, nWords: 2'd0, words: {18'h0, 18'h0, 18'h0}};

        // Latency, flush write and done timing for 3,1,4,1,5,9.
        doReset();
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        foreach (vecs[0].digits[k]) begin end
        sendDigit(3); sendDigit(1); sendDigit(4); sendDigit(1); sendDigit(5);
        in_valid = 1'b1;
        in_digit = 4'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("pi we at T+1", 32'(mem_we), 32'd0);
        @(negedge clk);
        checkOutput("pi we at T+2", 32'(mem_we), 32'd1);
        checkOutput("pi addr0", 32'(mem_addr), 32'd0);
        checkOutput("pi data0", 32'(mem_d), 32'h36594);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("pi done early", 32'(done), 32'd0);
        checkOutput("pi in_ready in flush", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("pi done", 32'(done), 32'd1);
        checkOutput("pi flush we", 32'(mem_we), 32'd1);
        checkOutput("pi flush addr", 32'(mem_addr), 32'd1);
        checkOutput("pi flush data", 32'(mem_d), 32'h00000);
        @(negedge clk);
        checkOutput("pi done one cycle", 32'(done), 32'd0);
        checkOutput("pi digit_count", 32'(digit_count), 32'd6);

        // Table-driven vectors with fixed expected words.
        for (int v = 0; v < 5; v++) begin
            doReset();
            stimDigits.delete();
            nd = int'(vecs[v].nDigits);
            for (int i = 0; i < nd; i++) stimDigits.push_back(int'(vecs[v].digits[23 - 4 * i -: 4]));
            expWords.delete();
            for (int i = 0; i < int'(vecs[v].nWords); i++) expWords.push_back(vecs[v].words[53 - 18 * i -: 18]);
            applyStimulus(0, 1'b0);
            collectAndCheck($sformatf("vec%0d", v));
        end

        // Empty flush: done two cycles after the pulse, later flushes ignored.
        doReset();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("empty done early", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("empty done", 32'(done), 32'd1);
        checkOutput("empty no write", 32'(mem_we), 32'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("done ignores flush", 32'(doneCount), 32'd1);
        checkOutput("done in_ready", 32'(in_ready), 32'd0);

        // 54 nines fill exactly ten words; flush adds nothing.
        doReset();
        stimDigits.delete();
        repeat (54) stimDigits.push_back(9);
        modelPack();
        applyStimulus(0, 1'b0);
        collectAndCheck("nines");
        checkOutput("nines count", 32'(capData.size()), 32'd10);
        if (capData.size() > 0) checkOutput("nines word0", 32'(capData[0]), 32'h3FCFF);

        // Reset state after a dirty run.
        doReset();
        checkOutput("rst mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst mem_d", 32'(mem_d), 32'd0);
        checkOutput("rst digit_count", 32'(digit_count), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst err", 32'(err), 32'd0);
        checkOutput("rst in_ready", 32'(in_ready), 32'd1);

        // Reset mid-run discards four pending digits.
        sendDigit(9); sendDigit(9); sendDigit(9); sendDigit(9);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst count", 32'(digit_count), 32'd0);
        stimDigits = '{0, 0, 0};
        expWords   = '{18'h00000};
        applyStimulus(0, 1'b0);
        collectAndCheck("midrst");

        // Reset on the edge that would register a write suppresses it.
        doReset();
        sendDigit(3); sendDigit(1); sendDigit(4); sendDigit(1); sendDigit(5); sendDigit(9);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst blocks write", 32'(mem_we), 32'd0);
        rst = 1'b1;

`ifdef PI_DIGIT_PACKER_CHECK_EN
        doReset();
        stimDigits = '{10, 0, 0};
        expWords   = '{18'h00000};
        applyStimulus(0, 1'b0);
        collectAndCheck("bad digit");
        checkOutput("bad digit err", 32'(err), 32'd1);
`else
        doReset();
        stimDigits = '{10, 0, 0};
        applyStimulus(0, 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("bad digit err", 32'(err), 32'd0);
`endif

        // Randomized runs against the reference model.
        for (int run = 0; run < 20; run++) begin
            doReset();
            stimDigits.delete();
            nd = $urandom_range(60, 0);
            for (int i = 0; i < nd; i++) stimDigits.push_back($urandom_range(9, 0));
            modelPack();
            applyStimulus($urandom_range(2, 0), 1'($urandom_range(1, 0)));
            collectAndCheck($sformatf("rand%0d", run));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/pi_digit_packer.md
Name: pi_digit_packer

Overview:
- Producer side of the pi digit store: accepts a stream of decimal digits and packs them into the 18-bit pi memory words.
- Each run of three consecutive digits is encoded as one 10-bit densely packed decimal (DPD) group, then bit-packed LSB-first into 18-bit words and written to sequential addresses.
- The resulting layout is exactly the one the digit lookup path decodes, so pi_get_digit can read memory images built by this block.

Parameters:
- N, 24: width of the memory address and of the digit counter.
- MEM_W, 18: memory word width. Fixed at 18; other values are unsupported.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset. rst==0 at a clk edge resets the block.
- in_valid  in  1  in_digit is valid this cycle.
- in_digit  in  4  BCD digit, 0..9.
- in_ready  out  1  block accepts in_digit this cycle.
- flush  in  1  single-cycle pulse: pad and write out all pending bits.
- mem_we  out  1  write strobe, one cycle per word.
- mem_addr  out  N  word address.
- mem_d  out  18  word data.
- digit_count  out  N  number of digits accepted since reset.
- done  out  1  one-cycle pulse after the flush completes.
- err  out  1  sticky flag for an invalid digit (see Optional Feature).

Behaviour:
- Handshake: a digit is accepted when in_valid && in_ready at a clk edge. in_ready=1 in state RUN and 0 in FLUSH/DONE.
- Digit order: the digit accepted at index i, with i%3==0, is the hundreds digit of group i/3; i%3==1 is tens; i%3==2 is units.
- Encoding: standard IEEE 754-2008 DPD, 3 BCD digits to 10 bits. It is a pure function held in a separate always/function.
- Bit layout: group g occupies global bit positions 10g..10g+9, LSB first. Global bit p maps to word p/18, bit p%18.
- Pipeline:
  - Stage 1: triplet register plus 2-bit phase counter (0,1,2, wraps to 0).
  - Stage 2: registered DPD group plus group-valid.
  - Stage 3: 28-bit accumulator with a 5-bit fill count (0..27).
  - On group-valid: acc |= group << fill, and fill += 10.
  - When fill >= 18: emit acc[17:0], shift acc right by 18, fill -= 18. Append and emit happen in the same cycle when both apply.
- Write timing: mem_we, mem_addr and mem_d are registered. A word completed by the digit accepted in cycle T is written in cycle T+2. mem_addr starts at 0 and increments after each write, wrapping at 2^N.
- Accumulator overflow is impossible, since at most one group arrives per 3 accepted digits. No backpressure from memory is needed.
- FSM states RUN, FLUSH, DONE:
  - RUN -> FLUSH on flush=1. A digit accepted in the same cycle as flush is included.
  - FLUSH waits until the pipeline is drained, i.e. stage 1 and stage 2 have been pushed into the accumulator.
  - A partial triplet (phase 1 or 2) is completed with zero digits.
  - If fill > 0 after that, one final word is written with zero padding in the upper bits.
  - FLUSH -> DONE, with done high for exactly one cycle on entry.
  - DONE holds until reset. in_ready=0 and further flush pulses are ignored.
- flush with nothing pending (phase 0, fill 0) writes no word; done follows 2 cycles later.
- digit_count increments on every accepted digit and wraps at 2^N.
- Reset: state=RUN, phase=0, fill=0, acc=0, mem_addr=0, mem_we=0, mem_d=0, digit_count=0, done=0, err=0, in_ready=1 on the first cycle after reset.
- Reset asserted mid-operation discards all pending digits and bits. No write occurs in the cycle after a reset edge.

Optional Feature:
- Macro: PI_DIGIT_PACKER_CHECK_EN.
- Defined: an accepted in_digit > 9 sets err (sticky until reset) and is replaced by 0 before encoding.
- Undefined: err is tied to 0 and digits are encoded as given. Results for values above 9 are unspecified.

Test Plan:
- Reset released; send digits 3,1,4,1,5,9 back-to-back, then flush. Required response:
  - Groups are 0x194 and 0x0D9.
  - First write: addr 0, data 0x36594, 2 cycles after digit '9' is accepted.
  - Flush write: addr 1, data 0x00000.
  - Then one done pulse; digit_count=6.
- Send 1,4,1 then flush: one write, addr 0, data 0x000C1, then done.
- Send 9 repeated 54 times, no flush: 18 groups of 0x0FF. Ten writes at addr 0..9, each word matching the bit layout, e.g. word0 = 0x3FCFF. Then flush writes nothing extra, because fill is 0.
- Send 2 digits (7,7) then flush: triplet padded to 7,7,0. Group 0x3F0 is written at addr 0 as 0x003F0.
- Assert rst=0 after 4 digits, release, send 0,0,0 then flush: only addr 0, data 0, is written. digit_count=3 and no stale bits appear.
- With PI_DIGIT_PACKER_CHECK_EN: send 0xA,0,0 then flush: err=1, written word 0x00000. Without the macro: err stays 0.
